// File: rtl/sync_ram_16x4_mod_if.sv
// rtl/sync_ram_16x4_mod_if.sv - bus bundle for the floor-request store
// Write/shift controls, address and registered read data.
interface sync_ram_16x4_mod_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic              we;
   logic              weT;
   logic              shift;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] q;

   modport master (
      output we, weT, shift, data, addr,
      input  q
   );

   modport slave (
      input  we, weT, shift, data, addr,
      output q
   );
endinterface

// File: rtl/sync_ram_16x4_mod.sv
// rtl/sync_ram_16x4_mod.sv - 16x4 floor-request RAM with queue push/pop
// Addressed writes, tail appends and a pop-by-shift; registered read-old port.
module sync_ram_16x4_mod #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sync_ram_16x4_mod_if.slave    bus
);
   localparam logic [ADDR_W:0] TAIL_FULL = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [ADDR_W:0]   tail_q;
   logic [ADDR_W:0]   tail_d;
   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] q_d;

   always_comb begin
      mem_d  = mem_q;
      tail_d = tail_q;
      // Read samples the array before this edge's update.
      q_d    = mem_q[bus.addr];
      if (bus.shift) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         mem_d[DEPTH-1] = '0;
         if (tail_q != '0) begin
            tail_d = tail_q - 1'b1;
         end
      end else if (bus.we) begin
         mem_d[bus.addr] = bus.data;
      end else if (bus.weT) begin
         if (tail_q < TAIL_FULL) begin
            mem_d[tail_q[ADDR_W-1:0]] = bus.data;
            tail_d = tail_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         tail_q <= '0;
         q_q    <= '0;
      end else begin
         mem_q  <= mem_d;
         tail_q <= tail_d;
         q_q    <= q_d;
      end
   end

   assign bus.q = q_q;
endmodule

// File: tb/tb_sync_ram_16x4_mod.sv
// tb/tb_sync_ram_16x4_mod.sv - directed self-checking bench for sync_ram_16x4_mod
// Linear directed steps; read data and tail checked against hand-computed values.
module tb_sync_ram_16x4_mod;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   sync_ram_16x4_mod_if #(.DATA_W(4), .ADDR_W(4)) bus ();

   sync_ram_16x4_mod dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.weT = 1'b0; bus.shift = 1'b0;
   endtask

   task automatic rd(input string tag, input int a, input int exp);
      bus.addr = 4'(a);
      step();
      chk(tag, int'(bus.q), exp);
   endtask

   task automatic chk_tail(input string tag, input int exp);
      chk(tag, int'(dut.tail_q), exp);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      bus.data = 4'd0;
      bus.addr = 4'd0;
      step();
      step();
      chk("rst_q", int'(bus.q), 0);
      chk_tail("rst_tail", 0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) rd("rst_mem", i, 0);

      // addressed write, read-old then new value
      bus.addr = 4'd2; bus.data = 4'd10; bus.we = 1'b1;
      step();
      chk("we_read_old", int'(bus.q), 0);
      bus.we = 1'b0;
      step();
      chk("we_read_new", int'(bus.q), 10);
      chk_tail("we_tail", 0);

      bus.data = 4'd8; bus.weT = 1'b1;
      step();
      chk_tail("push1_tail", 1);
      bus.data = 4'd5;
      step();
      chk_tail("push2_tail", 2);
      idle();
      rd("push_m0", 0, 8);
      rd("push_m1", 1, 5);
      rd("push_m2", 2, 10);

      bus.shift = 1'b1;
      step();
      idle();
      chk_tail("shift_tail", 1);
      rd("shift_m0", 0, 5);
      rd("shift_m1", 1, 10);
      rd("shift_m2", 2, 0);
      rd("shift_m15", 15, 0);

      // shift beats we and weT: mem = {10,0,...}, tail 0
      bus.addr = 4'd3; bus.data = 4'd7;
      bus.shift = 1'b1; bus.we = 1'b1; bus.weT = 1'b1;
      step();
      idle();
      chk_tail("prio_shift_tail", 0);
      rd("prio_shift_m3", 3, 0);
      rd("prio_shift_m0", 0, 10);

      // we beats weT
      bus.addr = 4'd5; bus.data = 4'd6; bus.we = 1'b1; bus.weT = 1'b1;
      step();
      idle();
      chk_tail("prio_we_tail", 0);
      rd("prio_we_m5", 5, 6);
      rd("prio_we_m0", 0, 10);

      bus.shift = 1'b1;
      step();
      idle();
      chk_tail("shift_empty_tail", 0);
      rd("shift_empty_m4", 4, 6);
      rd("shift_empty_m0", 0, 0);

      // fill: weT held 16 edges, then a 17th push that must be ignored
      bus.weT = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.data = 4'(15 - i);
         step();
      end
      chk_tail("full_tail", 16);
      bus.data = 4'd3;
      step();
      idle();
      chk_tail("overflow_tail", 16);
      for (int i = 0; i < 16; i++) rd("full_mem", i, 15 - i);

      bus.shift = 1'b1;
      for (int i = 0; i < 14; i++) step();
      idle();
      chk_tail("pop14_tail", 2);
      rd("pop14_m0", 0, 1);

      // reset overrides all enables
      bus.addr = 4'd0; bus.data = 4'd9;
      bus.we = 1'b1; bus.weT = 1'b1; bus.shift = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      chk("midrst_q", int'(bus.q), 0);
      chk_tail("midrst_tail", 0);
      for (int i = 0; i < 16; i++) rd("midrst_mem", i, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
